// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions for the instruction sequencer: FSM states,
// one-hot phase codes and the opcodes the sequencer recognises.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_START,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_UPDATE,
        ST_HALT,
        ST_FAULT
    } state_t;

    localparam logic [3:0] EN_NONE   = 4'b0000;
    localparam logic [3:0] EN_FETCH  = 4'b0001;
    localparam logic [3:0] EN_DECODE = 4'b0010;
    localparam logic [3:0] EN_EXEC   = 4'b0100;
    localparam logic [3:0] EN_UPDATE = 4'b1000;

    localparam logic [7:0] OP_JMP  = 8'h10;
    localparam logic [7:0] OP_BEQ  = 8'h11;
    localparam logic [7:0] OP_BNE  = 8'h12;
    localparam logic [7:0] OP_HALT = 8'hFF;

    // Phase code presented while the FSM sits in a given state.
    function automatic logic [3:0] phase_of(input state_t st);
        case (st)
            ST_FETCH:  return EN_FETCH;
            ST_DECODE: return EN_DECODE;
            ST_EXEC:   return EN_EXEC;
            ST_UPDATE: return EN_UPDATE;
            default:   return EN_NONE;
        endcase
    endfunction

endpackage

// File: rtl/branch_unit.sv
// Combinational branch resolution: PC-relative target from a signed imm24
// and the taken decision for JMP/BEQ/BNE.
module branch_unit
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [23:0] imm24,
    input  logic [7:0]  opcode,
    input  logic        alu_zero,
    output logic [31:0] target,
    output logic        taken
);

    assign target = pc + {{8{imm24[23]}}, imm24};

    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_JMP:  taken = 1'b1;
            OP_BEQ:  taken = alu_zero;
            OP_BNE:  taken = ~alu_zero;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute/update sequencer feeding the program counter; fetches
// over a req/ack port with a bounded wait and resolves branches.
module instr_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  en,
    output logic [31:0] IR,
    output logic [7:0]  S,
    output logic [31:0] Pcp,
    output logic        z,
    output logic        halted,
    output logic        fault
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t      state_reg, state_next;
    logic [7:0]  wait_cnt_reg, wait_cnt_next;
    logic [3:0]  en_reg;
    logic [31:0] ir_reg, pcp_reg;
    logic        z_reg, halted_reg, fault_reg;
    logic [31:0] br_target;
    logic        br_taken;

    branch_unit u_branch (
        .pc       (PC),
        .imm24    (ir_reg[23:0]),
        .opcode   (ir_reg[31:24]),
        .alu_zero (alu_zero),
        .target   (br_target),
        .taken    (br_taken)
    );

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_START:  state_next = ST_FETCH;
            ST_FETCH: begin
                // An ack on the final permitted cycle still wins over the timeout.
                if (mem_ack) begin
                    state_next    = ST_DECODE;
                    wait_cnt_next = 8'd0;
                end else if (wait_cnt_reg == WAIT_LAST) begin
                    state_next = ST_FAULT;
                end else begin
                    wait_cnt_next = wait_cnt_reg + 8'd1;
                end
            end
            ST_DECODE: state_next = (ir_reg[31:24] == OP_HALT) ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_next = ST_UPDATE;
            ST_UPDATE: state_next = ST_FETCH;
            default:   state_next = state_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_START;
            wait_cnt_reg <= 8'd0;
            en_reg       <= EN_NONE;
            ir_reg       <= 32'd0;
            pcp_reg      <= 32'd0;
            z_reg        <= 1'b0;
            halted_reg   <= 1'b0;
            fault_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            en_reg       <= phase_of(state_next);
            halted_reg   <= (state_next == ST_HALT);
            fault_reg    <= (state_next == ST_FAULT);
            if (state_reg == ST_FETCH && mem_ack)
                ir_reg <= mem_rdata;
            if (state_reg == ST_DECODE)
                pcp_reg <= br_target;
            if (state_reg == ST_EXEC)
                z_reg <= br_taken;
            // Branch results are only meaningful until the next fetch begins.
            if (state_next == ST_FETCH) begin
                pcp_reg <= 32'd0;
                z_reg   <= 1'b0;
            end
        end
    end

    assign mem_req  = (state_reg == ST_FETCH);
    assign mem_addr = mem_req ? PC : 32'd0;
    assign en       = en_reg;
    assign IR       = ir_reg;
    assign S        = ir_reg[31:24];
    assign Pcp      = pcp_reg;
    assign z        = z_reg;
    assign halted   = halted_reg;
    assign fault    = fault_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a table of single-instruction vectors
// plus hand sequences for phase cycling, timeout, reset and halt.
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        alu_zero;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [3:0]  en;
    logic [31:0] IR;
    logic [7:0]  S;
    logic [31:0] Pcp;
    logic        z;
    logic        halted;
    logic        fault;

    int total = 0;
    int bad   = 0;

    instr_sequencer #(.TIMEOUT(15)) dut (
        .clk       (clk),
        .rst       (rst),
        .PC        (PC),
        .alu_zero  (alu_zero),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .en        (en),
        .IR        (IR),
        .S         (S),
        .Pcp       (Pcp),
        .z         (z),
        .halted    (halted),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] word;
        logic        az;
        int          delay;   // FETCH cycles without ack before the ack cycle
        logic [31:0] exp_pcp;
        logic        exp_z;
    } vec_t;

    vec_t vecs[8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ack = 1'b0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 0,  32'h0000_0000, 1'b0};
        vecs[1] = '{32'h0000_0010, 32'h1100_0005, 1'b1, 0,  32'h0000_0015, 1'b1};
        vecs[2] = '{32'h0000_0002, 32'h12FF_FFFD, 1'b1, 0,  32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{32'h0000_0100, 32'h1000_0001, 1'b0, 3,  32'h0000_0101, 1'b1};
        vecs[4] = '{32'h0000_0040, 32'h11FF_FFF0, 1'b0, 0,  32'h0000_0030, 1'b0};
        vecs[5] = '{32'h8000_0000, 32'h1200_0010, 1'b0, 1,  32'h8000_0010, 1'b1};
        vecs[6] = '{32'h0000_0020, 32'h1000_0008, 1'b0, 14, 32'h0000_0028, 1'b1};
        vecs[7] = '{32'h0000_1000, 32'h3380_0000, 1'b1, 0,  32'hFF80_1000, 1'b0};

        rst = 1'b1; PC = '0; alu_zero = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        step(); step();

        // Reset state
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_IR", IR, 32'h0);
        chk("rst_Pcp", Pcp, 32'h0);
        chk("rst_flags", {29'd0, z, halted, fault}, 32'h0);

        // Table-driven single instructions
        for (int v = 0; v < 8; v++) begin
            PC = vecs[v].pc; alu_zero = vecs[v].az; mem_rdata = vecs[v].word;
            do_reset();
            chk("start_en", 32'(en), 32'h0);
            step();
            for (int i = 0; i <= vecs[v].delay; i++) begin
                chk("fetch_en", 32'(en), 32'h1);
                chk("fetch_req", 32'(mem_req), 32'h1);
                chk("fetch_addr", mem_addr, vecs[v].pc);
                mem_ack = (i == vecs[v].delay);
                step();
            end
            mem_ack = 1'b0;
            chk("decode_en", 32'(en), 32'h2);
            chk("decode_IR", IR, vecs[v].word);
            step();
            chk("exec_en", 32'(en), 32'h4);
            chk("exec_req", 32'(mem_req), 32'h0);
            step();
            chk("update_en", 32'(en), 32'h8);
            chk("update_S", 32'(S), 32'(vecs[v].word[31:24]));
            chk("update_Pcp", Pcp, vecs[v].exp_pcp);
            chk("update_z", 32'(z), 32'(vecs[v].exp_z));
            chk("update_fault", 32'(fault), 32'h0);
            step();
            chk("next_en", 32'(en), 32'h1);
            chk("next_z", 32'(z), 32'h0);
            chk("next_Pcp", Pcp, 32'h0);
            $display("vec %0d pc=%h word=%h delay=%0d Pcp=%h z=%0b", v, vecs[v].pc, vecs[v].word, vecs[v].delay, vecs[v].exp_pcp, vecs[v].exp_z);
        end

        // Zero-wait phase cycling over three instructions
        begin
            logic [3:0] seq[5];
            seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100; seq[3] = 4'b1000; seq[4] = 4'b0001;
            PC = 32'h0; mem_rdata = 32'h0; alu_zero = 1'b0;
            do_reset();
            mem_ack = 1'b1;
            chk("cyc_start", 32'(en), 32'h0);
            step();
            for (int c = 0; c < 12; c++) begin
                chk("cyc_en", 32'(en), 32'(seq[c % 4]));
                chk("cyc_req", 32'(mem_req), 32'(en == 4'b0001));
                chk("cyc_z", 32'(z), 32'h0);
                step();
            end
            mem_ack = 1'b0;
            $display("seq zero-wait cycling done");
        end

        // Fetch timeout
        PC = 32'h44; mem_rdata = 32'h1000_0000;
        do_reset();
        step();
        for (int i = 0; i < 15; i++) begin
            chk("to_fetch_en", 32'(en), 32'h1);
            chk("to_fault_low", 32'(fault), 32'h0);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            chk("to_fault", 32'(fault), 32'h1);
            chk("to_en", 32'(en), 32'h0);
            chk("to_req", 32'(mem_req), 32'h0);
            mem_ack = 1'b1;
            step();
        end
        mem_ack = 1'b0;
        $display("seq timeout fault=%0b", fault);

        // Reset during EXECUTE
        PC = 32'h10; mem_rdata = 32'h1100_0005; alu_zero = 1'b1;
        do_reset();
        step();
        mem_ack = 1'b1; step();
        mem_ack = 1'b0; step();
        chk("rx_pre_en", 32'(en), 32'h4);
        rst = 1'b1; step();
        chk("rx_en", 32'(en), 32'h0);
        chk("rx_IR", IR, 32'h0);
        chk("rx_S", 32'(S), 32'h0);
        chk("rx_Pcp", Pcp, 32'h0);
        chk("rx_flags", {28'd0, mem_req, z, halted, fault}, 32'h0);
        chk("rx_addr", mem_addr, 32'h0);
        rst = 1'b0;
        $display("seq reset in execute done");

        // Reset mid-FETCH with ack pending: no IR load
        do_reset();
        step();
        mem_rdata = 32'hDEAD_BEEF; mem_ack = 1'b1; rst = 1'b1;
        step();
        chk("rf_IR", IR, 32'h0);
        chk("rf_en", 32'(en), 32'h0);
        rst = 1'b0; mem_ack = 1'b0;
        $display("seq reset in fetch done");

        // HALT
        PC = 32'h8; mem_rdata = 32'hFF00_0000;
        do_reset();
        step();
        mem_ack = 1'b1; step();
        mem_ack = 1'b0;
        chk("h_decode_en", 32'(en), 32'h2);
        step();
        for (int i = 0; i < 4; i++) begin
            chk("h_halted", 32'(halted), 32'h1);
            chk("h_en", 32'(en), 32'h0);
            chk("h_req", 32'(mem_req), 32'h0);
            chk("h_fault", 32'(fault), 32'h0);
            step();
        end
        $display("seq halt halted=%0b", halted);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
